// File: rtl/execute_hazard_unit.sv
// Execute-stage hazard unit: holds the execute instruction, picks operand
// forwarding sources, and stalls upstream while a chosen source is still pending.
module execute_hazard_unit #(
  parameter int NUM_FWD   = 2,
  parameter int STALL_MAX = 4,
  localparam int SEL_W    = $clog2(NUM_FWD + 2),
  localparam int CNT_W    = $clog2(STALL_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            instr_in,
  input  logic                   instr_valid_in,
  input  logic                   use_a_in,
  input  logic                   use_b_in,
  input  logic                   use_s_in,
  input  logic                   flush,
  input  logic [NUM_FWD-1:0]     fwd_valid,
  input  logic [4*NUM_FWD-1:0]   fwd_rd,
  input  logic [NUM_FWD-1:0]     fwd_pending,
  output logic [31:0]            instr_out,
  output logic                   ex_valid,
  output logic [SEL_W-1:0]       sel_A_in,
  output logic [SEL_W-1:0]       sel_B_in,
  output logic [SEL_W-1:0]       sel_shift_in,
  output logic                   en_A,
  output logic                   en_B,
  output logic                   en_S,
  output logic                   stall_out,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic                   stall_timeout
);

  typedef enum logic {RUN, STALL} state_e;

  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(NUM_FWD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             use_a_q, use_a_d;
  logic             use_b_q, use_b_d;
  logic             use_s_q, use_s_d;
  state_e           state_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             stall_timeout_q;
  logic [CNT_W-1:0] stall_cycles_d;

  logic [SEL_W-1:0] sel_a, sel_b, sel_s;
  logic             pend_a, pend_b, pend_s;

  // Downward scan so the youngest (lowest-numbered) matching source wins.
  function automatic logic [SEL_W-1:0] pickSource(
    input logic                 active,
    input logic [3:0]           idx,
    input logic [NUM_FWD-1:0]   fv,
    input logic [4*NUM_FWD-1:0] frd
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (active) begin
      if (idx == 4'hF) begin
        sel = SEL_PC;
      end else begin
        for (int k = NUM_FWD; k >= 1; k--) begin
          if (fv[k-1] && (frd[4*k-1 -: 4] == idx)) sel = SEL_W'(k);
        end
      end
    end
    return sel;
  endfunction

  function automatic logic isPending(
    input logic [SEL_W-1:0]   sel,
    input logic [NUM_FWD-1:0] fp
  );
    logic p;
    p = 1'b0;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (sel == SEL_W'(k)) p = fp[k-1];
    end
    return p;
  endfunction

  always_comb begin
    sel_a  = pickSource(valid_q & use_a_q, instr_q[19:16], fwd_valid, fwd_rd);
    sel_b  = pickSource(valid_q & use_b_q, instr_q[3:0],   fwd_valid, fwd_rd);
    sel_s  = pickSource(valid_q & use_s_q, instr_q[11:8],  fwd_valid, fwd_rd);
    pend_a = isPending(sel_a, fwd_pending);
    pend_b = isPending(sel_b, fwd_pending);
    pend_s = isPending(sel_s, fwd_pending);
  end

  // Only the chosen source can stall, so a shadowed older load is ignored.
  assign stall_out    = valid_q & ~flush & (pend_a | pend_b | pend_s);
  assign sel_A_in     = sel_a;
  assign sel_B_in     = sel_b;
  assign sel_shift_in = sel_s;
  assign en_A         = valid_q & use_a_q & ~stall_out;
  assign en_B         = valid_q & use_b_q & ~stall_out;
  assign en_S         = valid_q & use_s_q & ~stall_out;
  assign instr_out    = instr_q;
  assign ex_valid     = valid_q;
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = stall_timeout_q;

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    use_a_d = use_a_q;
    use_b_d = use_b_q;
    use_s_d = use_s_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall_out) begin
      instr_d = instr_in;
      valid_d = instr_valid_in;
      use_a_d = use_a_in;
      use_b_d = use_b_in;
      use_s_d = use_s_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      use_a_q <= 1'b0;
      use_b_q <= 1'b0;
      use_s_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      use_a_q <= use_a_d;
      use_b_q <= use_b_d;
      use_s_q <= use_s_d;
    end
  end

  // Counter value if this edge stalls: a fresh stall starts at 1, otherwise saturate.
  always_comb begin
    stall_cycles_d = CNT_W'(1);
    if (state_q == STALL) begin
      stall_cycles_d = (stall_cycles_q == CNT_MAX) ? stall_cycles_q
                                                   : stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      stall_cycles_q  <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_out && !flush) begin
            state_q        <= STALL;
            stall_cycles_q <= stall_cycles_d;
            if (stall_cycles_d == CNT_MAX) stall_timeout_q <= 1'b1;
          end else begin
            stall_cycles_q <= '0;
          end
        end
        STALL: begin
          if (!stall_out || flush) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
          end else begin
            stall_cycles_q <= stall_cycles_d;
            if (stall_cycles_d == CNT_MAX) stall_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q        <= RUN;
          stall_cycles_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_hazard_unit.sv
// Scoreboard bench for execute_hazard_unit: a reference model predicts every
// output each cycle, plus targeted checks for forwarding, stall, flush and reset.
module tb_execute_hazard_unit;

  localparam int NUM_FWD   = 2;
  localparam int STALL_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        use_a_in = 1'b0, use_b_in = 1'b0, use_s_in = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  fwd_valid = '0;
  logic [7:0]  fwd_rd = '0;
  logic [1:0]  fwd_pending = '0;
  logic [31:0] instr_out;
  logic        ex_valid;
  logic [1:0]  sel_A_in, sel_B_in, sel_shift_in;
  logic        en_A, en_B, en_S, stall_out;
  logic [2:0]  stall_cycles;
  logic        stall_timeout;

  always #5 clk = ~clk;

  execute_hazard_unit #(.NUM_FWD(NUM_FWD), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
    .use_a_in(use_a_in), .use_b_in(use_b_in), .use_s_in(use_s_in), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_pending(fwd_pending),
    .instr_out(instr_out), .ex_valid(ex_valid), .sel_A_in(sel_A_in),
    .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in), .en_A(en_A), .en_B(en_B),
    .en_S(en_S), .stall_out(stall_out), .stall_cycles(stall_cycles),
    .stall_timeout(stall_timeout)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  sa, sb, ss;
    logic        ea, eb, es, stall;
    logic [2:0]  cnt;
    logic        to;
  } exp_t;

  exp_t sbQueue[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] mInstr;
  logic        mValid, mUseA, mUseB, mUseS, mTimeout;
  logic [2:0]  mCnt;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs);
    return {12'hE00, rn, 4'h0, rs, 4'h0, rm};
  endfunction

  function automatic void modelReset();
    mInstr = '0; mValid = 1'b0; mUseA = 1'b0; mUseB = 1'b0; mUseS = 1'b0;
    mCnt = '0; mTimeout = 1'b0;
  endfunction

  // Reference select: PC for r15, else source 1 before source 2, else register file.
  function automatic logic [1:0] modelSel(input logic used, input logic [3:0] idx);
    if (!mValid || !used) return 2'd0;
    if (idx == 4'd15) return 2'd3;
    if (fwd_valid[0] && fwd_rd[3:0] == idx) return 2'd1;
    if (fwd_valid[1] && fwd_rd[7:4] == idx) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic modelPend(input logic [1:0] sel);
    if (sel == 2'd1) return fwd_pending[0];
    if (sel == 2'd2) return fwd_pending[1];
    return 1'b0;
  endfunction

  function automatic exp_t computeExpected();
    exp_t e;
    e.instr = mInstr;
    e.valid = mValid;
    e.sa    = modelSel(mUseA, mInstr[19:16]);
    e.sb    = modelSel(mUseB, mInstr[3:0]);
    e.ss    = modelSel(mUseS, mInstr[11:8]);
    e.stall = mValid && !flush && (modelPend(e.sa) || modelPend(e.sb) || modelPend(e.ss));
    e.ea    = mValid && mUseA && !e.stall;
    e.eb    = mValid && mUseB && !e.stall;
    e.es    = mValid && mUseS && !e.stall;
    e.cnt   = mCnt;
    e.to    = mTimeout;
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic ua,
                               input logic ub, input logic us, input logic fl,
                               input logic [1:0] fv, input logic [7:0] frd, input logic [1:0] fp);
    @(negedge clk);
    instr_in = ins; instr_valid_in = v; use_a_in = ua; use_b_in = ub; use_s_in = us;
    flush = fl; fwd_valid = fv; fwd_rd = frd; fwd_pending = fp;
    sbQueue.push_back(computeExpected());
  endtask

  task automatic checkResult(input string tag);
    exp_t e;
    #1;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({tag, ".instr"}, instr_out, e.instr);
      checkOutput({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
      checkOutput({tag, ".sels"}, {26'd0, sel_A_in, sel_B_in, sel_shift_in}, {26'd0, e.sa, e.sb, e.ss});
      checkOutput({tag, ".ens"}, {29'd0, en_A, en_B, en_S}, {29'd0, e.ea, e.eb, e.es});
      checkOutput({tag, ".stall"}, {31'd0, stall_out}, {31'd0, e.stall});
      checkOutput({tag, ".cnt"}, {29'd0, stall_cycles}, {29'd0, e.cnt});
      checkOutput({tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, e.to});
    end
  endtask

  // Clock the model in step with the DUT's rising edge.
  task automatic advance();
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else begin
      e = computeExpected();
      if (e.stall) begin
        mCnt = (mCnt == 3'(STALL_MAX)) ? mCnt : mCnt + 3'd1;
        if (mCnt == 3'(STALL_MAX)) mTimeout = 1'b1;
      end else begin
        mCnt = '0;
      end
      if (flush) begin
        mValid = 1'b0;
      end else if (!e.stall) begin
        mInstr = instr_in; mValid = instr_valid_in;
        mUseA = use_a_in; mUseB = use_b_in; mUseS = use_s_in;
      end
    end
  endtask

  task automatic runCycle(input string tag, input logic [31:0] ins, input logic v,
                          input logic ua, input logic ub, input logic us, input logic fl,
                          input logic [1:0] fv, input logic [7:0] frd, input logic [1:0] fp);
    applyStimulus(ins, v, ua, ub, us, fl, fv, frd, fp);
    checkResult(tag);
    advance();
  endtask

  logic [31:0] hazInstr;
  logic [31:0] otherInstr;

  initial begin
    modelReset();
    hazInstr   = mkInstr(4'd4, 4'd0, 4'd0);
    otherInstr = mkInstr(4'd7, 4'd8, 4'd9);

    applyStimulus(32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 8'h00, 2'b11);
    checkResult("reset");
    advance();
    #1 rst_n = 1'b1;

    // Both sources hold r3: the younger one forwards.
    runCycle("load_rn3", mkInstr(4'd3, 4'd7, 4'd9), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h33, 2'b00);
    checkResult("youngest");
    checkOutput("youngest.selA", {30'd0, sel_A_in}, 32'd1);
    checkOutput("youngest.enA", {31'd0, en_A}, 32'd1);
    checkOutput("youngest.stall", {31'd0, stall_out}, 32'd0);
    advance();

    runCycle("load_pc", mkInstr(4'd0, 4'd15, 4'd5), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 2'b00);
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h03, 2'b00);
    checkResult("pc_sel");
    checkOutput("pc_sel.selB", {30'd0, sel_B_in}, 32'd3);
    checkOutput("pc_sel.selS", {30'd0, sel_shift_in}, 32'd0);
    advance();

    runCycle("load_multi", mkInstr(4'd3, 4'd4, 4'd3), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 2'b00);
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h43, 2'b00);
    checkResult("multi");
    checkOutput("multi.sels", {26'd0, sel_A_in, sel_B_in, sel_shift_in}, {26'd0, 2'd1, 2'd2, 2'd1});
    advance();

    // Shadowed older pending source must not stall.
    runCycle("load_shadow", hazInstr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h44, 2'b10);
    checkResult("shadow");
    checkOutput("shadow.stall", {31'd0, stall_out}, 32'd0);
    advance();

    runCycle("load_haz", hazInstr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(otherInstr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 2'b01);
      checkResult("stall2");
      checkOutput("stall2.stall", {31'd0, stall_out}, 32'd1);
      checkOutput("stall2.enA", {31'd0, en_A}, 32'd0);
      checkOutput("stall2.hold", instr_out, hazInstr);
      checkOutput("stall2.cnt", {29'd0, stall_cycles}, i);
      advance();
    end
    applyStimulus(otherInstr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 2'b00);
    checkResult("release");
    checkOutput("release.enA", {31'd0, en_A}, 32'd1);
    advance();
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    checkResult("after_release");
    checkOutput("after_release.cnt", {29'd0, stall_cycles}, 32'd0);
    checkOutput("after_release.instr", instr_out, otherInstr);
    advance();

    runCycle("load_long", hazInstr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    for (int i = 0; i < 6; i++)
      runCycle("long_stall", otherInstr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 2'b01);
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    checkResult("saturate");
    checkOutput("saturate.cnt", {29'd0, stall_cycles}, 32'd4);
    checkOutput("saturate.timeout", {31'd0, stall_timeout}, 32'd1);
    advance();
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    checkResult("sticky");
    checkOutput("sticky.timeout", {31'd0, stall_timeout}, 32'd1);
    checkOutput("sticky.cnt", {29'd0, stall_cycles}, 32'd0);
    advance();

    runCycle("load_flush", hazInstr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    applyStimulus(otherInstr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'h04, 2'b01);
    checkResult("flush");
    checkOutput("flush.stall", {31'd0, stall_out}, 32'd0);
    advance();
    applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 2'b01);
    checkResult("post_flush");
    checkOutput("post_flush.valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("post_flush.cnt", {29'd0, stall_cycles}, 32'd0);
    advance();

    // Asynchronous reset dropped mid-cycle while stalled.
    runCycle("load_rst", hazInstr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00);
    runCycle("rst_stall", otherInstr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 2'b01);
    applyStimulus(otherInstr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 2'b01);
    checkResult("pre_async");
    #1 rst_n = 1'b0;
    modelReset();
    sbQueue.push_back(computeExpected());
    checkResult("async_rst");
    checkOutput("async_rst.stall", {31'd0, stall_out}, 32'd0);
    checkOutput("async_rst.timeout", {31'd0, stall_timeout}, 32'd0);
    checkOutput("async_rst.instr", instr_out, 32'd0);
    advance();
    #1 rst_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      logic [3:0] rn, rm, rs;
      rn = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      rm = 4'($urandom_range(0, 5));
      rs = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      runCycle("random", mkInstr(rn, rm, rs), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
               {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))},
               {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_hazard_unit.md
EXECUTE_HAZARD_UNIT -- requirements
Module: execute_hazard_unit

Interface
REQ-001 Parameter NUM_FWD, default 2, number of downstream forwarding sources; source 1 is the youngest.
REQ-002 Parameter STALL_MAX, default 4, stall-cycle count at which stall_timeout sets.
REQ-003 Derived SEL_W = $clog2(NUM_FWD+2); CNT_W = $clog2(STALL_MAX+1).
REQ-004 Clocking: one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 instr_in  in  32  instruction from decode.
REQ-008 instr_valid_in  in  1  instr_in is valid.
REQ-009 use_a_in, use_b_in, use_s_in  in  1 each  instruction reads Rn, Rm, Rs respectively.
REQ-010 flush  in  1  branch flush; kills the held instruction.
REQ-011 fwd_valid  in  NUM_FWD  source k holds a live destination.
REQ-012 fwd_rd  in  4*NUM_FWD  destination index of source k, bits [4k-1:4k-4].
REQ-013 fwd_pending  in  NUM_FWD  source k result not yet available (load in flight).
REQ-014 instr_out  out  32  held execute-stage instruction.
REQ-015 ex_valid  out  1  held instruction is valid.
REQ-016 sel_A_in, sel_B_in, sel_shift_in  out  SEL_W each  operand source select for Rn, Rm, Rs.
REQ-017 en_A, en_B, en_S  out  1 each  operand register enables.
REQ-018 stall_out  out  1  hold upstream stages.
REQ-019 stall_cycles  out  CNT_W  consecutive stall cycles, saturating.
REQ-020 stall_timeout  out  1  sticky: stall reached STALL_MAX.

Function
REQ-021 Fields of the held instruction: rn=[19:16], rm=[3:0], rs=[11:8].
REQ-022 Holding register update at each rising edge, priority order: flush clears ex_valid; else stall_out holds all state; else it captures instr_in, instr_valid_in and the use bits.
REQ-023 Select encoding: 0 = register file; k (1..NUM_FWD) = forward from source k; NUM_FWD+1 = PC.
REQ-024 For each used operand: index 15 selects PC; otherwise the lowest k with fwd_valid[k] and fwd_rd[k]==index selects k; otherwise 0.
REQ-025 Unused operands and ex_valid=0 force the select to 0.
REQ-026 en_A = ex_valid & use_a & ~stall_out; en_B and en_S follow the same rule with use_b and use_s.
REQ-027 stall_out = ex_valid & ~flush & (any used operand's chosen source k has fwd_pending[k]=1).
REQ-028 Only the chosen (youngest matching) source decides pending; a pending older match that is shadowed by a younger source does not stall.
REQ-029 Selects, enables and stall_out are combinational from the held state and fwd inputs, with 0-cycle latency.
REQ-030 FSM states: RUN and STALL. RUN->STALL when stall_out=1 at a clock edge. STALL->RUN when stall_out=0 or flush=1.
REQ-031 stall_cycles increments at each edge where stall_out=1, saturating at STALL_MAX; it clears at any edge where stall_out=0 or flush=1.
REQ-032 stall_timeout sets at the edge where stall_cycles becomes STALL_MAX; it clears only on reset.
REQ-033 flush and a hazard in the same cycle: flush wins; stall_out=0 and the next instruction is not captured, so ex_valid=0 next cycle.
REQ-034 Simultaneous matches on several operands resolve independently per operand.

Reset
REQ-035 While rst_n=0: ex_valid=0, instr_out=0, use bits=0, FSM=RUN, stall_cycles=0, stall_timeout=0. Hence all selects=0, all enables=0, stall_out=0.
REQ-036 Reset asserted mid-stall returns to the REQ-035 values immediately, without waiting for a clock edge.

Verification (NUM_FWD=2, STALL_MAX=4)
REQ-037 Source 1 and source 2 both valid with rd=3; instruction uses rn=3 -> sel_A_in=1, en_A=1, stall_out=0.
REQ-038 rm=15 with use_b=1 -> sel_B_in=3 (PC); rs=5 with no match -> sel_shift_in=0.
REQ-039 rn=4 matches source 1 with fwd_pending[1]=1 for 2 cycles, then 0 -> stall_out=1 for 2 cycles, instr_out held, en_A=0; then en_A=1 and stall_cycles returns to 0.
REQ-040 Pending held for 6 cycles -> stall_cycles saturates at 4 and stall_timeout=1; stall_timeout stays 1 after the hazard clears, until rst_n=0.
REQ-041 Hazard present and flush=1 in the same cycle -> stall_out=0; next cycle ex_valid=0 and stall_cycles=0.
REQ-042 rst_n=0 pulsed between clock edges during a stall -> outputs reach the REQ-035 values before the next edge.
